// File: rtl/uart_pkg.sv
// uart_pkg: definitions shared by the UART transmitter and receiver.
//   uart_state_e         : frame FSM states (IDLE=0, START=1, DATA=2, STOP=3)
//   CLKS_PER_BIT_DEFAULT : clk cycles per bit for 50 MHz / 9600 baud
//   DATA_BITS            : payload bits per frame (8N1)
package uart_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      START = 2'd1,
      DATA  = 2'd2,
      STOP  = 2'd3
   } uart_state_e;

   localparam int unsigned CLKS_PER_BIT_DEFAULT = 5208;
   localparam int unsigned DATA_BITS            = 8;

endpackage

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: synchronous single-clock byte FIFO with show-ahead output.
//   clk, rst : clock, asynchronous active-high reset (pointers/count only)
//   push     : write din (ignored while full)
//   pop      : advance head (ignored while empty)
//   din      : byte to write
//   dout     : current head byte, valid whenever !empty
//   full     : count == DEPTH
//   empty    : count == 0
//   count    : number of buffered bytes
module uart_tx_fifo
   import uart_pkg::*;
#(
   parameter int DEPTH = 16
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   push,
   input  logic                   pop,
   input  logic [DATA_BITS-1:0]   din,
   output logic [DATA_BITS-1:0]   dout,
   output logic                   full,
   output logic                   empty,
   output logic [$clog2(DEPTH):0] count
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

   logic [DATA_BITS-1:0] mem_q [DEPTH];
   logic [AW-1:0]        wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]        rd_ptr_q, rd_ptr_d;
   logic [AW:0]          count_q,  count_d;
   logic                 push_ok,  pop_ok;

   assign full    = (count_q == FULL_CNT);
   assign empty   = (count_q == '0);
   assign count   = count_q;
   assign dout    = mem_q[rd_ptr_q];
   assign push_ok = push && !full;
   assign pop_ok  = pop && !empty;

   // DEPTH is a power of two, so pointers wrap by plain overflow.
   always_comb begin
      wr_ptr_d = wr_ptr_q + AW'(push_ok);
      rd_ptr_d = rd_ptr_q + AW'(pop_ok);
      count_d  = count_q;
      case ({push_ok, pop_ok})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Storage carries no reset; stale entries are unreachable once pointers clear.
   always_ff @(posedge clk) begin
      if (push_ok) begin
         mem_q[wr_ptr_q] <= din;
      end
   end

endmodule

// File: rtl/uart_tx_buffered.sv
// uart_tx_buffered: 8N1 UART transmitter fed by a byte FIFO.
//   clk        : system clock, all logic on its rising edge
//   rst        : asynchronous active-high reset, aborts any frame
//   tx_data    : byte to transmit
//   tx_valid   : tx_data valid this cycle
//   tx_ready   : FIFO can accept a byte (= !full)
//   tx         : registered serial line, idle high
//   tx_busy    : frame in progress or bytes still buffered
//   fifo_count : bytes currently buffered
module uart_tx_buffered
   import uart_pkg::*;
#(
   parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT,
   parameter int FIFO_DEPTH   = 16
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic [7:0]                  tx_data,
   input  logic                        tx_valid,
   output logic                        tx_ready,
   output logic                        tx,
   output logic                        tx_busy,
   output logic [$clog2(FIFO_DEPTH):0] fifo_count
);

   localparam logic [15:0] CNT_MAX  = 16'(CLKS_PER_BIT - 1);
   localparam logic [2:0]  LAST_BIT = 3'(DATA_BITS - 1);

   uart_state_e   state_q, state_d;
   logic [15:0]   cnt_q,   cnt_d;
   logic [2:0]    bit_q,   bit_d;
   logic [7:0]    shift_q, shift_d;
   logic          tx_q,    tx_d;

   logic          fifo_pop;
   logic [7:0]    fifo_dout;
   logic          fifo_full;
   logic          fifo_empty;
   logic          tick;

   uart_tx_fifo #(
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (tx_valid),
      .pop   (fifo_pop),
      .din   (tx_data),
      .dout  (fifo_dout),
      .full  (fifo_full),
      .empty (fifo_empty),
      .count (fifo_count)
   );

   assign tx_ready = !fifo_full;
   assign tx       = tx_q;
   assign tx_busy  = (state_q != IDLE) || (fifo_count != '0);
   assign tick     = (cnt_q == CNT_MAX);

   // tx_d is the line level for the current state; registering it puts the
   // start bit on the line one edge after the IDLE->START pop, giving the
   // two-edge write-to-start latency and a glitch-free output.
   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q + 16'd1;
      bit_d    = bit_q;
      shift_d  = shift_q;
      tx_d     = 1'b1;
      fifo_pop = 1'b0;
      case (state_q)
         IDLE: begin
            cnt_d = '0;
            if (!fifo_empty) begin
               fifo_pop = 1'b1;
               shift_d  = fifo_dout;
               bit_d    = '0;
               state_d  = START;
            end
         end
         START: begin
            tx_d = 1'b0;
            if (tick) begin
               cnt_d   = '0;
               bit_d   = '0;
               state_d = DATA;
            end
         end
         DATA: begin
            tx_d = shift_q[0];
            if (tick) begin
               cnt_d   = '0;
               shift_d = shift_q >> 1;
               bit_d   = bit_q + 3'd1;
               if (bit_q == LAST_BIT) begin
                  state_d = STOP;
               end
            end
         end
         STOP: begin
            tx_d = 1'b1;
            if (tick) begin
               cnt_d = '0;
               // Chain straight into the next frame when more data is waiting.
               if (!fifo_empty) begin
                  fifo_pop = 1'b1;
                  shift_d  = fifo_dout;
                  bit_d    = '0;
                  state_d  = START;
               end else begin
                  state_d = IDLE;
               end
            end
         end
         default: begin
            cnt_d   = '0;
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         bit_q   <= '0;
         shift_q <= '0;
         tx_q    <= 1'b1;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         bit_q   <= bit_d;
         shift_q <= shift_d;
         tx_q    <= tx_d;
      end
   end

endmodule

// File: tb/tb_uart_tx_buffered.sv
module tb_uart_tx_buffered;

   localparam int CPB   = 4;
   localparam int DEPTH = 4;
   localparam int FRAME = 10 * CPB;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [7:0] tx_data = 8'h00;
   logic       tx_valid = 1'b0;
   logic       tx_ready;
   logic       tx;
   logic       tx_busy;
   logic [2:0] fifo_count;

   uart_tx_buffered #(
      .CLKS_PER_BIT (CPB),
      .FIFO_DEPTH   (DEPTH)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .tx_data    (tx_data),
      .tx_valid   (tx_valid),
      .tx_ready   (tx_ready),
      .tx         (tx),
      .tx_busy    (tx_busy),
      .fifo_count (fifo_count)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int nvec = 0;
   int nerr = 0;
   logic [7:0] exp_q[$];
   int         start_q[$];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      nvec++;
      if (act !== exp) begin
         nerr++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic chk_start(input string name, input int idx, input int exp);
      if (start_q.size() > idx) chk(name, start_q[idx], exp);
      else chk(name, 32'hFFFF_FFFF, exp);
   endtask

   // ---------------- monitor: decode the line, pop expected bytes ----------------
   task automatic mwait(input int n, inout logic ab);
      repeat (n) begin
         @(negedge clk);
         if (rst) ab = 1'b1;
      end
   endtask

   initial begin : monitor
      logic [7:0] b;
      logic       ab;
      forever begin
         @(negedge clk);
         if (!rst && tx === 1'b0) begin
            start_q.push_back(cyc);
            ab = 1'b0;
            b  = 8'h00;
            mwait(CPB/2, ab);
            if (!ab) chk("start_bit_mid", tx, 0);
            for (int i = 0; i < 8 && !ab; i++) begin
               mwait(CPB, ab);
               b[i] = tx;
            end
            if (!ab) mwait(CPB, ab);
            if (!ab) begin
               chk("stop_bit", tx, 1);
               if (exp_q.size() == 0) begin
                  nvec++;
                  nerr++;
                  $display("FAIL unexpected_byte: got 0x%0h, expected no frame", b);
               end else begin
                  chk("rx_byte", b, exp_q.pop_front());
               end
               mwait(CPB/2 - 1, ab);
            end
         end
      end
   end

   // ---------------- stimulus ----------------
   task automatic send(input logic [7:0] b, output int acc);
      int n = 0;
      while (!tx_ready && n < 4 * FRAME) begin
         @(posedge clk); #1;
         n++;
      end
      if (!tx_ready) begin
         chk("send_ready_timeout", tx_ready, 1);
         acc = cyc;
      end else begin
         tx_valid = 1'b1;
         tx_data  = b;
         @(posedge clk); #1;
         tx_valid = 1'b0;
         acc = cyc;
         exp_q.push_back(b);
      end
   endtask

   task automatic wait_cyc(input int target);
      while (cyc < target) begin
         @(posedge clk); #1;
      end
   endtask

   task automatic wait_idle(input int budget);
      int n = 0;
      while ((exp_q.size() != 0 || tx_busy) && n < budget) begin
         @(posedge clk); #1;
         n++;
      end
      repeat (CPB) begin
         @(posedge clk); #1;
      end
      chk("drain_pending_bytes", exp_q.size(), 0);
      chk("drain_tx_busy", tx_busy, 0);
   endtask

   initial begin : stim
      int acc, a0, a1;
      logic [7:0] seq [6];
      seq[0] = 8'h11; seq[1] = 8'h22; seq[2] = 8'h33;
      seq[3] = 8'h44; seq[4] = 8'h66; seq[5] = 8'h77;

      // reset state
      repeat (3) @(posedge clk);
      #1;
      chk("rst_tx", tx, 1);
      chk("rst_count", fifo_count, 0);
      chk("rst_busy", tx_busy, 0);
      chk("rst_ready", tx_ready, 1);
      rst = 1'b0;
      @(posedge clk); #1;
      chk("ready_after_rst", tx_ready, 1);

      // single byte 0xA5 from idle: latency, frame length, busy drop
      start_q.delete();
      send(8'hA5, acc);
      wait_cyc(acc + 1);
      chk("a5_tx_before_start", tx, 1);
      wait_cyc(acc + 2);
      chk("a5_tx_start_edge", tx, 0);
      wait_cyc(acc + 40);
      chk("a5_busy_in_stop", tx_busy, 1);
      wait_cyc(acc + 41);
      chk("a5_busy_after_stop", tx_busy, 0);
      chk("a5_tx_stop", tx, 1);
      chk_start("a5_start_cycle", 0, acc + 2);
      wait_idle(2 * FRAME);

      // back-to-back 00, FF, 55: contiguous frames
      start_q.delete();
      send(8'h00, a0);
      send(8'hFF, acc);
      send(8'h55, acc);
      wait_idle(4 * FRAME);
      chk_start("b2b_start0", 0, a0 + 2);
      chk_start("b2b_start1", 1, a0 + 2 + FRAME);
      chk_start("b2b_start2", 2, a0 + 2 + 2 * FRAME);

      // fill to full, extra byte held on tx_valid must be rejected
      for (int i = 0; i < 5; i++) send(seq[i], acc);
      chk("full_count", fifo_count, 4);
      chk("full_ready", tx_ready, 0);
      tx_valid = 1'b1;
      tx_data  = seq[5];
      for (int i = 0; i < 3; i++) begin
         @(posedge clk); #1;
         chk("full_push_ignored", fifo_count, 4);
      end
      tx_valid = 1'b0;
      wait_idle(7 * FRAME);

      // simultaneous push/pop keeps count and the pushed byte
      start_q.delete();
      send(8'hC0, a0);
      send(8'hC1, acc);
      chk("pushpop_idle_count", fifo_count, 1);
      send(8'hC2, acc);
      send(8'hC3, acc);
      wait_cyc(a0 + 40);
      chk("pre_stop_pop_count", fifo_count, 3);
      chk("pre_stop_pop_ready", tx_ready, 1);
      tx_valid = 1'b1;
      tx_data  = 8'hC4;
      @(posedge clk); #1;
      tx_valid = 1'b0;
      exp_q.push_back(8'hC4);
      chk("stop_pushpop_count", fifo_count, 3);
      wait_idle(6 * FRAME);
      chk_start("stop_chain_start", 1, a0 + 42);

      // reset during data bit 3 with two bytes queued
      send(8'hF7, a0);
      send(8'h81, acc);
      send(8'h42, acc);
      wait_cyc(a0 + 19);
      chk("bit3_level", tx, 0);
      chk("bit3_queued", fifo_count, 2);
      rst = 1'b1;
      #1;
      chk("abort_tx", tx, 1);
      chk("abort_count", fifo_count, 0);
      chk("abort_busy", tx_busy, 0);
      chk("abort_ready", tx_ready, 1);
      exp_q.delete();
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      @(posedge clk); #1;
      start_q.delete();
      send(8'h3C, a1);
      wait_idle(2 * FRAME);
      chk_start("post_rst_start", 0, a1 + 2);

      // loopback of 256 random bytes
      for (int i = 0; i < 256; i++) send(8'($urandom_range(0, 255)), acc);
      wait_idle(260 * FRAME);

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

   initial begin : watchdog
      #(10 * 60000);
      $display("FAIL watchdog: simulation exceeded 60000 cycles, expected completion");
      $fatal(1, "timeout");
   end

endmodule
